mips_multicycle_ctrl: RTL



---
 rtl/mips_ctrl_pkg.sv | 41 ++++
 rtl/mips_ctrl_outdec.sv | 91 +++++++++
 rtl/mips_multicycle_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS main control FSM.
//   Opcode constants, ALUOp class codes and the 4-bit state encoding.
//   Optional feature macro: MIPS_CTRL_BNE_EN adds the BRANCH_NE state.
package mips_ctrl_pkg;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned STATE_W  = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    // Explicit encodings; values 12..15 (13..15 with BNE) are unencoded.
    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
`ifdef MIPS_CTRL_BNE_EN
        , S_BRANCH_NE = 4'd12
`endif
    } state_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Moore decode of the FSM state into datapath controls (purely combinational).
//   in : state
//   out: alu_op, alu_src_a, alu_src_b, pc_src, iord, reg_dst, mem_to_reg,
//        reg_write, branch, branch_ne, pc_write (unconditional PC write),
//        fetch (IR/PC write pending MemReady), mem_write_req (store pending).
//   Optional feature macro: MIPS_CTRL_BNE_EN.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t      state,
    output logic [1:0]  alu_op,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_src,
    output logic        iord,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        branch,
    output logic        branch_ne,
    output logic        pc_write,
    output logic        fetch,
    output logic        mem_write_req
);

    // State-to-control table; everything defaults to 0 / 2'b00.
    always_comb begin
        alu_op        = ALUOP_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_src        = 2'b00;
        iord          = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        branch        = 1'b0;
        branch_ne     = 1'b0;
        pc_write      = 1'b0;
        fetch         = 1'b0;
        mem_write_req = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b = 2'b01;
                fetch     = 1'b1;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR, S_ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord          = 1'b1;
                mem_write_req = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
`ifdef MIPS_CTRL_BNE_EN
            S_BRANCH_NE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = 2'b01;
                branch_ne = 1'b1;
            end
`endif
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
//   in : clk, reset (sync, active-high), Op, Zero, MemReady
//   out: ALUOp, ALUSrcA, ALUSrcB, PCSrc, IorD, MemWrite, IRWrite, RegWrite,
//        RegDst, MemtoReg, PCEn, Illegal (sticky undefined-opcode flag)
//   Parameters: ILLEGAL_TRAP, RESET_PC_WRITE.
//   Optional feature macro: MIPS_CTRL_BNE_EN (adds bne via BRANCH_NE).
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned ILLEGAL_TRAP   = 1,
    parameter int unsigned RESET_PC_WRITE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Op,
    input  logic        Zero,
    input  logic        MemReady,
    output logic [1:0]  ALUOp,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSrc,
    output logic        IorD,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        PCEn,
    output logic        Illegal
);

    localparam logic TRAP_EN    = 1'(ILLEGAL_TRAP != 0);
    localparam logic PC_HOLD_EN = 1'(RESET_PC_WRITE != 0);

    state_t state;
    state_t state_nxt;
    logic   illegal_set;
    logic   illegal_q;
    logic   first_fetch;

    logic   dec_reg_write;
    logic   dec_branch;
    logic   dec_branch_ne;
    logic   dec_pc_write;
    logic   dec_fetch;
    logic   dec_mem_write_req;
    logic   run;
    logic   pc_hold;
    logic   pc_write;

    // State register, sticky Illegal and post-reset first-fetch marker.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FETCH;
            illegal_q   <= 1'b0;
            first_fetch <= 1'b1;
        end else begin
            state <= state_nxt;
            if (illegal_set && TRAP_EN)
                illegal_q <= 1'b1;
            if (state == S_FETCH && MemReady)
                first_fetch <= 1'b0;
        end
    end

    // Next-state logic; unencoded states fall back to FETCH.
    always_comb begin
        state_nxt   = S_FETCH;
        illegal_set = 1'b0;
        case (state)
            S_FETCH:  state_nxt = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXECUTE;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_ADDI:      state_nxt = S_ADDIEXEC;
                    OP_J:         state_nxt = S_JUMP;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:       state_nxt = S_BRANCH_NE;
`endif
                    default: begin
                        state_nxt   = S_FETCH;
                        illegal_set = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_nxt = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_nxt = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:    state_nxt = MemReady ? S_FETCH : S_MEMWR;
            S_EXECUTE:  state_nxt = S_ALUWB;
            S_ADDIEXEC: state_nxt = S_ADDIWB;
            default:    state_nxt = S_FETCH;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state         (state),
        .alu_op        (ALUOp),
        .alu_src_a     (ALUSrcA),
        .alu_src_b     (ALUSrcB),
        .pc_src        (PCSrc),
        .iord          (IorD),
        .reg_dst       (RegDst),
        .mem_to_reg    (MemtoReg),
        .reg_write     (dec_reg_write),
        .branch        (dec_branch),
        .branch_ne     (dec_branch_ne),
        .pc_write      (dec_pc_write),
        .fetch         (dec_fetch),
        .mem_write_req (dec_mem_write_req)
    );

    // Strobes are forced low while reset is asserted so an abandoned
    // instruction cannot commit anything in the reset cycle.
    assign run      = ~reset;
    assign pc_hold  = PC_HOLD_EN & first_fetch;
    assign pc_write = run & (dec_pc_write | (dec_fetch & MemReady & ~pc_hold));

    assign IRWrite  = run & dec_fetch & MemReady;
    assign MemWrite = run & dec_mem_write_req & ~MemReady;
    assign RegWrite = run & dec_reg_write;
    assign PCEn     = pc_write
                    | (run & dec_branch    &  Zero)
                    | (run & dec_branch_ne & ~Zero);
    assign Illegal  = TRAP_EN & illegal_q;

endmodule
